// File: rtl/preset_recorder_if.sv
// Signal bundle between the physics engine side (master) and the preset recorder (slave).
interface preset_recorder_if #(
    parameter int SPRITES    = 2,
    parameter int DIMENSIONS = 2,
    parameter int WIDTH      = 32,
    parameter int SLOTS      = 4
) ();
    localparam int SW = $clog2(SLOTS);

    logic                                          capture;
    logic                                          clear;
    logic [SW-1:0]                                 slot_wr;
    logic [SW-1:0]                                 slot_rd;
    logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] live_loc;
    logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] live_vel;
    logic                                          busy;
    logic                                          done;
    logic [SLOTS-1:0]                              valid;
    logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] loc;
    logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] vel;

    modport master (
        output capture, clear, slot_wr, slot_rd, live_loc, live_vel,
        input  busy, done, valid, loc, vel
    );

    modport slave (
        input  capture, clear, slot_wr, slot_rd, live_loc, live_vel,
        output busy, done, valid, loc, vel
    );
endinterface

// File: rtl/preset_recorder.sv
// Captures live physics-engine state into preset slots, one word pair per cycle,
// and reads a selected slot back as registered, valid-masked initial conditions.
//
// state | meaning
// IDLE  | waiting for capture; clear zeroes valid
// WRITE | copying shadow word idx into slot tgt
// DONE  | one-cycle completion pulse
module preset_recorder #(
    parameter int SPRITES    = 2,
    parameter int DIMENSIONS = 2,
    parameter int WIDTH      = 32,
    parameter int SLOTS      = 4
) (
    input logic              clock_162,
    input logic              rst_n,
    preset_recorder_if.slave bus
);
    localparam int K  = SPRITES * DIMENSIONS;
    localparam int SW = $clog2(SLOTS);
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int BW = K * WIDTH;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic              accept;
    logic              last;
    logic [IW-1:0]     idx_q;
    logic [SW-1:0]     tgt_q;
    logic [SLOTS-1:0]  valid_q;
    logic [BW-1:0]     shadow_loc, shadow_vel;
    logic [BW-1:0]     mem_loc [SLOTS];
    logic [BW-1:0]     mem_vel [SLOTS];
    logic [BW-1:0]     loc_q, vel_q;

    assign last = (idx_q == IW'(K - 1));

    always_ff @(posedge clock_162) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.capture && !bus.clear) begin
                    accept  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (bus.clear) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_162) begin
        if (!rst_n) begin
            valid_q <= '0;
            idx_q   <= '0;
            tgt_q   <= '0;
            loc_q   <= '0;
            vel_q   <= '0;
        end else begin
            // Masking by valid keeps a slot under rewrite reading as zeros.
            loc_q <= valid_q[bus.slot_rd] ? mem_loc[bus.slot_rd] : '0;
            vel_q <= valid_q[bus.slot_rd] ? mem_vel[bus.slot_rd] : '0;
            if (bus.clear) begin
                valid_q <= '0;
            end else if (accept) begin
                tgt_q                <= bus.slot_wr;
                idx_q                <= '0;
                valid_q[bus.slot_wr] <= 1'b0;
            end else if (state_q == WRITE) begin
                idx_q <= idx_q + 1'b1;
                if (last) begin
                    valid_q[tgt_q] <= 1'b1;
                end
            end
        end
    end

    // Snapshot and slot storage carry no reset; valid masks stale contents.
    always_ff @(posedge clock_162) begin
        if (accept) begin
            shadow_loc <= bus.live_loc;
            shadow_vel <= bus.live_vel;
        end
        if (state_q == WRITE && !bus.clear) begin
            for (int k = 0; k < K; k++) begin
                if (idx_q == IW'(k)) begin
                    mem_loc[tgt_q][k*WIDTH +: WIDTH] <= shadow_loc[k*WIDTH +: WIDTH];
                    mem_vel[tgt_q][k*WIDTH +: WIDTH] <= shadow_vel[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign bus.busy  = (state_q == WRITE);
    assign bus.done  = (state_q == DONE);
    assign bus.valid = valid_q;
    assign bus.loc   = loc_q;
    assign bus.vel   = vel_q;
endmodule
